// File: rtl/qspi_pkg.sv
// Shared types and constants for the quad-SPI flash read controller.
package qspi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_DESEL
  } state_t;

  // Placement of the flash pins on the uio bus.
  localparam int unsigned PIN_CS  = 0;
  localparam int unsigned PIN_SCK = 3;
  localparam int unsigned PIN_IO [3:0] = '{5, 4, 2, 1};

  // IO0 drives serial bits, IO1 floats, IO2/IO3 hold WP#/HOLD# high.
  localparam logic [3:0] OE_CMD = 4'b1101;

  // Serial bits sent before the dummy phase: opcode plus 24-bit address.
  localparam int unsigned HDR_BITS = 32;
  localparam int unsigned CNT_W    = 6;

endpackage

// File: rtl/qspi_shift_reg.sv
// 32-bit shifter: serialises {opcode, address} one bit per slot and
// gathers read data four bits per slot.
module qspi_shift_reg
  import qspi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        shift1,
  input  logic        shift4,
  input  logic [3:0]  din,
  output logic        bit_next,
  output logic [3:0]  nib
);

  logic [31:0] q;

  // Load, rotate one bit toward the MSB, or shift in a nibble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift1) begin
      q <= {q[30:0], q[31]};
    end else if (shift4) begin
      q <= {q[27:0], din};
    end
  end

  assign bit_next = q[30];
  assign nib      = q[3:0];

endmodule

// File: rtl/qspi_read_ctrl.sv
// Quad-SPI Fast Read Quad Output (0x6B) master with a valid/ready byte stream.
module qspi_read_ctrl
  import qspi_pkg::*;
#(
  parameter int unsigned LEN_W        = 8,
  parameter logic [7:0]  CMD          = 8'h6B,
  parameter int unsigned DUMMY_CYCLES = 8,
  parameter int unsigned CS_HIGH_CLKS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [23:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  output logic             data_valid,
  input  logic             data_ready,
  output logic [7:0]       data_out,
  output logic             data_last,
  output logic             qspi_cs_n,
  output logic             qspi_sck,
  output logic [3:0]       qspi_io_out,
  output logic [3:0]       qspi_io_oe,
  input  logic [3:0]       qspi_io_in
);

  localparam int unsigned GUARD_W = (CS_HIGH_CLKS > 1) ? $clog2(CS_HIGH_CLKS) : 1;
  localparam logic [GUARD_W-1:0] GUARD_MAX = GUARD_W'(CS_HIGH_CLKS - 1);

  state_t             state;
  logic               ph;
  logic               half;
  logic [CNT_W-1:0]   cnt;
  logic [LEN_W-1:0]   bcnt;
  logic [GUARD_W-1:0] gcnt;

  logic       sr_load;
  logic       sr_shift1;
  logic       sr_shift4;
  logic       sr_bit_next;
  logic [3:0] sr_nib;
  logic       drain_ok;

  // Shifter strobes: load on handshake, shift at the end of each sck-high phase.
  always_comb begin
    sr_load   = (state == ST_IDLE) && req_ready && req_valid;
    sr_shift1 = ph && ((state == ST_CMD) || (state == ST_ADDR));
    sr_shift4 = ph && (state == ST_DATA);
    drain_ok  = !data_valid || data_ready;
  end

  qspi_shift_reg u_sr (
    .clk      (clk),
    .rst      (rst),
    .load     (sr_load),
    .load_val ({CMD, req_addr}),
    .shift1   (sr_shift1),
    .shift4   (sr_shift4),
    .din      (qspi_io_in),
    .bit_next (sr_bit_next),
    .nib      (sr_nib)
  );

  // Transaction sequencer with registered pin and stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      ph          <= 1'b0;
      half        <= 1'b0;
      cnt         <= '0;
      bcnt        <= '0;
      gcnt        <= '0;
      req_ready   <= 1'b0;
      qspi_cs_n   <= 1'b1;
      qspi_sck    <= 1'b0;
      qspi_io_oe  <= '0;
      qspi_io_out <= '0;
      data_valid  <= 1'b0;
      data_last   <= 1'b0;
      data_out    <= '0;
    end else begin
      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
        data_last  <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (req_ready) begin
            if (req_valid) begin
              req_ready   <= 1'b0;
              state       <= ST_CMD;
              ph          <= 1'b0;
              cnt         <= '0;
              bcnt        <= req_len;
              qspi_cs_n   <= 1'b0;
              qspi_sck    <= 1'b0;
              qspi_io_oe  <= OE_CMD;
              qspi_io_out <= {2'b11, 1'b0, CMD[7]};
            end
          end else if (gcnt == GUARD_MAX) begin
            req_ready <= 1'b1;
          end else begin
            gcnt <= gcnt + GUARD_W'(1);
          end
        end

        ST_CMD, ST_ADDR: begin
          if (!ph) begin
            ph       <= 1'b1;
            qspi_sck <= 1'b1;
          end else begin
            ph       <= 1'b0;
            qspi_sck <= 1'b0;
            cnt      <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(HDR_BITS - 1)) begin
              state       <= ST_DUMMY;
              cnt         <= '0;
              qspi_io_oe  <= '0;
              qspi_io_out <= '0;
            end else begin
              qspi_io_out[0] <= sr_bit_next;
              if (cnt == CNT_W'(7)) begin
                state <= ST_ADDR;
              end
            end
          end
        end

        ST_DUMMY: begin
          if (!ph) begin
            ph       <= 1'b1;
            qspi_sck <= 1'b1;
          end else begin
            ph       <= 1'b0;
            qspi_sck <= 1'b0;
            if (cnt == CNT_W'(DUMMY_CYCLES - 1)) begin
              state <= ST_DATA;
              cnt   <= '0;
              half  <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        ST_DATA: begin
          if (!ph) begin
            // At a byte boundary, wait with sck low until the output slot drains.
            if (half || drain_ok) begin
              ph       <= 1'b1;
              qspi_sck <= 1'b1;
            end
          end else begin
            ph       <= 1'b0;
            qspi_sck <= 1'b0;
            if (!half) begin
              half <= 1'b1;
            end else begin
              half       <= 1'b0;
              data_valid <= 1'b1;
              data_out   <= {sr_nib, qspi_io_in};
              data_last  <= (bcnt == '0);
              if (bcnt == '0) begin
                state     <= ST_DESEL;
                qspi_cs_n <= 1'b1;
                gcnt      <= '0;
              end else begin
                bcnt <= bcnt - LEN_W'(1);
              end
            end
          end
        end

        ST_DESEL: begin
          if ((gcnt == GUARD_MAX) && drain_ok) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
          end else if (gcnt != GUARD_MAX) begin
            gcnt <= gcnt + GUARD_W'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_read_ctrl.sv
// Bench for qspi_read_ctrl: behavioural flash model plus stream scoreboard.
module tb_qspi_read_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic [7:0]  req_len;
  logic        data_valid;
  logic        data_ready;
  logic [7:0]  data_out;
  logic        data_last;
  logic        qspi_cs_n;
  logic        qspi_sck;
  logic [3:0]  qspi_io_out;
  logic [3:0]  qspi_io_oe;
  logic [3:0]  qspi_io_in;

  qspi_read_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .data_out    (data_out),
    .data_last   (data_last),
    .qspi_cs_n   (qspi_cs_n),
    .qspi_sck    (qspi_sck),
    .qspi_io_out (qspi_io_out),
    .qspi_io_oe  (qspi_io_oe),
    .qspi_io_in  (qspi_io_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard of expected stream bytes
  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;
  exp_t sb[$];

  logic [23:0] exp_addr;
  logic [7:0]  model_xor;

  // Flash model: captures opcode/address on IO0, returns byte(a) = a[7:0] ^ model_xor.
  int          mcnt = 0;
  logic [31:0] msh;
  logic [23:0] maddr;
  logic [23:0] ma;
  logic [7:0]  mb;
  logic        oe_bad;
  int          mk;

  always begin
    @(posedge qspi_sck or posedge qspi_cs_n);
    #1;
    if (qspi_cs_n) begin
      mcnt   = 0;
      oe_bad = 1'b0;
    end else begin
      mcnt++;
      if (mcnt <= 32) begin
        msh = {msh[30:0], qspi_io_out[0]};
        if (qspi_io_oe != 4'b1101 || qspi_io_out[3:2] != 2'b11) oe_bad = 1'b1;
        if (mcnt == 32) begin
          chk("flash_cmd", 32'(msh[31:24]), 32'h6B);
          chk("flash_addr", 32'(msh[23:0]), 32'(exp_addr));
          chk("hdr_oe", 32'(oe_bad), 32'd0);
          maddr = msh[23:0];
        end
      end else if (mcnt > 40) begin
        mk = mcnt - 41;
        ma = maddr + 24'(mk / 2);
        mb = ma[7:0] ^ model_xor;
        qspi_io_in = (mk % 2 == 0) ? mb[7:4] : mb[3:0];
        if (mcnt == 41) chk("data_oe", 32'(qspi_io_oe), 32'd0);
      end
    end
  end

  // Stream monitor and chip-select gap tracking
  bit   first_seen = 1'b0;
  int   first_cyc  = 0;
  int   last_cyc   = 0;
  int   npop       = 0;
  logic prev_cs    = 1'b1;
  bit   rise_valid = 1'b0;
  int   rise_cyc   = 0;
  exp_t e;

  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid && !first_seen) begin
        first_seen = 1'b1;
        first_cyc  = cyc;
      end
      if (data_valid && data_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_byte: got %0h expected none", data_out);
        end else begin
          e = sb.pop_front();
          chk("stream_data", 32'(data_out), 32'(e.data));
          chk("stream_last", 32'(data_last), 32'(e.last));
          npop++;
          if (data_last) last_cyc = cyc;
        end
      end
      if (prev_cs == 1'b0 && qspi_cs_n == 1'b1) begin
        rise_cyc   = cyc;
        rise_valid = 1'b1;
      end
      if (prev_cs == 1'b1 && qspi_cs_n == 1'b0 && rise_valid) begin
        total++;
        if (cyc - rise_cyc < 2) begin
          bad++;
          $display("FAIL cs_gap: got %0d expected >=2", cyc - rise_cyc);
        end
      end
      prev_cs = qspi_cs_n;
    end
  end

  // Issue one request; returns the first cs-low cycle.
  task automatic do_req(input logic [23:0] a, input logic [7:0] l, input logic [7:0] xr,
                        input bit keep, output int c0);
    int n;
    logic [23:0] aa;
    req_addr  = a;
    req_len   = l;
    req_valid = 1'b1;
    model_xor = xr;
    n = 0;
    c0 = 0;
    while (!req_ready && n < 3000) begin
      step();
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL req_timeout: got ready=0 expected ready=1");
    end else begin
      chk("prev_drained", 32'(sb.size()), 32'd0);
      for (int i = 0; i <= int'(l); i++) begin
        aa = a + 24'(i);
        sb.push_back('{data: aa[7:0] ^ xr, last: (i == int'(l))});
      end
      exp_addr   = a;
      first_seen = 1'b0;
      npop       = 0;
      step();
      c0 = cyc;
      chk("cs_low_at_C", 32'(qspi_cs_n), 32'd0);
    end
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!(sb.size() == 0 && req_ready) && n < 3000) begin
      step();
      n++;
    end
    if (!(sb.size() == 0 && req_ready)) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got pending=%0d expected 0", sb.size());
    end
  endtask

  typedef struct {
    logic [23:0] addr;
    logic [7:0]  len;
    logic [7:0]  xr;
    int          lat;
    int          span;
  } vec_t;

  vec_t vt[5];

  initial begin
    int c0;
    int n;
    int sck_hi;

    vt[0] = '{addr: 24'h000100, len: 8'd0,   xr: 8'h5A, lat: 84, span: 0};
    vt[1] = '{addr: 24'h012340, len: 8'd15,  xr: 8'h00, lat: 84, span: 60};
    vt[2] = '{addr: 24'hFFFFFE, len: 8'd3,   xr: 8'hA5, lat: 84, span: 12};
    vt[3] = '{addr: 24'hABCDEF, len: 8'd7,   xr: 8'h3C, lat: 84, span: 28};
    vt[4] = '{addr: 24'h000000, len: 8'd255, xr: 8'h00, lat: 84, span: 1020};

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_len    = '0;
    data_ready = 1'b1;
    qspi_io_in = '0;
    model_xor  = '0;
    exp_addr   = '0;

    // Reset values
    step(); step(); step();
    chk("rst_cs_n", 32'(qspi_cs_n), 32'd1);
    chk("rst_sck", 32'(qspi_sck), 32'd0);
    chk("rst_oe", 32'(qspi_io_oe), 32'd0);
    chk("rst_io_out", 32'(qspi_io_out), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_last", 32'(data_last), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    n = 0;
    while (!req_ready && n < 10) begin
      step();
      n++;
    end
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Table of full transfers with continuous data_ready
    foreach (vt[i]) begin
      do_req(vt[i].addr, vt[i].len, vt[i].xr, 1'b0, c0);
      while (cyc < c0 + 83 + 4 * int'(vt[i].len)) step();
      chk("cs_low_last_nib", 32'(qspi_cs_n), 32'd0);
      step();
      chk("cs_high_after", 32'(qspi_cs_n), 32'd1);
      chk("last_valid", 32'({data_valid, data_last}), 32'h3);
      wait_done();
      chk("first_latency", 32'(first_cyc - c0), 32'(vt[i].lat));
      chk("burst_span", 32'(last_cyc - first_cyc), 32'(vt[i].span));
      chk("byte_count", 32'(npop), 32'(int'(vt[i].len) + 1));
    end

    // Backpressure: stall 20 clk after the first byte appears
    do_req(24'h000300, 8'd3, 8'h77, 1'b0, c0);
    n = 0;
    while (!data_valid && n < 200) begin
      step();
      n++;
    end
    chk("bp_first_valid", 32'(data_valid), 32'd1);
    data_ready = 1'b0;
    sck_hi = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (qspi_sck) sck_hi++;
    end
    chk("bp_sck_frozen", 32'(sck_hi), 32'd0);
    chk("bp_cs_low", 32'(qspi_cs_n), 32'd0);
    chk("bp_held", 32'(data_valid), 32'd1);
    data_ready = 1'b1;
    wait_done();
    chk("bp_count", 32'(npop), 32'd4);

    // Reset in the middle of the address phase
    do_req(24'h000500, 8'd4, 8'h22, 1'b0, c0);
    while (cyc < c0 + 30) step();
    rst = 1'b1;
    #1;
    chk("mid_rst_cs", 32'(qspi_cs_n), 32'd1);
    chk("mid_rst_sck", 32'(qspi_sck), 32'd0);
    chk("mid_rst_oe", 32'(qspi_io_oe), 32'd0);
    sb.delete();
    step(); step();
    rst = 1'b0;
    n = 0;
    while (!req_ready && n < 10) begin
      step();
      n++;
    end
    chk("ready_after_mid_rst", 32'(req_ready), 32'd1);
    do_req(24'h000400, 8'd1, 8'h11, 1'b0, c0);
    wait_done();
    chk("post_rst_count", 32'(npop), 32'd2);

    // Back-to-back with req_valid held; last byte of the first held on the stream
    do_req(24'h000200, 8'd1, 8'h00, 1'b1, c0);
    req_addr = 24'h000600;
    req_len  = 8'd2;
    while (cyc < c0 + 86) step();
    data_ready = 1'b0;
    while (cyc < c0 + 95) step();
    chk("b2b_ready_blocked", 32'(req_ready), 32'd0);
    chk("b2b_last_pending", 32'({data_valid, data_last, qspi_cs_n}), 32'h7);
    data_ready = 1'b1;
    do_req(24'h000600, 8'd2, 8'h00, 1'b0, n);
    chk("b2b_order", 32'(n > last_cyc), 32'd1);
    wait_done();
    chk("b2b_count", 32'(npop), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/qspi_read_ctrl.md
Name: qspi_read_ctrl

Overview:
- Quad-SPI flash read master inside tt_um_htfab_asicle2; the flash model is attached to the uio pins.
- Pin map is fixed: cs0 on uio[0], sck on uio[3], io[1:0] on uio[2:1], io[3:2] on uio[5:4].
- Accepts a read request (24-bit address plus byte count) and issues a Fast Read Quad Output (0x6B) transaction.
- Returns the read bytes on a valid/ready stream to the game logic (word/dictionary fetch).

Parameters:
- LEN_W, 8, width of req_len; a transfer is req_len+1 bytes, 1..2^LEN_W.
- CMD, 8'h6B, flash opcode sent on IO0.
- DUMMY_CYCLES, 8, SCK cycles between address and data.
- CS_HIGH_CLKS, 2, minimum clk cycles cs_n stays high between transactions (≥1).

Ports:
- clk  in  1  system clock; SCK = clk/2 while running.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  read request valid.
- req_ready  out  1  controller idle and able to accept.
- req_addr  in  24  flash byte address.
- req_len  in  LEN_W  byte count minus one.
- data_valid  out  1  data_out holds a byte.
- data_ready  in  1  consumer accepts the byte.
- data_out  out  8  read byte.
- data_last  out  1  marks the final byte of the transfer.
- qspi_cs_n  out  1  chip select, active low.
- qspi_sck  out  1  serial clock, mode 0 (idles low).
- qspi_io_out  out  4  IO output values.
- qspi_io_oe  out  4  IO output enables, 1 = drive.
- qspi_io_in  in  4  IO input values.

Behaviour:
- Reset (async, whenever rst=1): state IDLE. Outputs: qspi_cs_n=1, qspi_sck=0, qspi_io_oe=0, qspi_io_out=0, data_valid=0, data_last=0, data_out=0, req_ready=0 while rst=1.
- Reset mid-transaction aborts immediately with the same pin values; no partial byte is presented afterwards.
- req_ready=1 only in IDLE once the CS_HIGH_CLKS guard has elapsed.
- Request handshake: on req_valid & req_ready, capture req_addr and req_len; cs_n goes low in the next cycle C.
- Bit slot = 2 clk:
  - Phase 0: sck=0; outputs change.
  - Phase 1: sck=1.
- States:
  - IDLE → CMD → ADDR → DUMMY → DATA → DESEL → IDLE.
- CMD, cycles C..C+15:
  - 8 bits of CMD MSB first on io[0].
  - oe=4'b1101; io_out[3:2]=2'b11 (WP#/HOLD# high).
- ADDR, C+16..C+63:
  - 24 address bits MSB first on io[0]; same oe/io_out as CMD.
- DUMMY:
  - 2*DUMMY_CYCLES clk, oe=0, io_out=0.
- DATA:
  - Each byte is 2 slots (4 clk), high nibble first, oe=0.
  - Nibble sampled from qspi_io_in on the clk edge that ends phase 1 (sck falls there).
- Latency: first data_valid=1 in cycle C+64+2*DUMMY_CYCLES+4, i.e. C+84 with defaults.
- Output register:
  - Holds one byte until data_valid & data_ready.
  - Next byte may complete in the same cycle the previous one is accepted.
- Stall:
  - If the next byte would complete while the output register is still full, hold sck=0 at the byte boundary until it drains.
  - cs_n stays low throughout.
- data_last=1 together with data_valid for byte req_len; stream order is ascending address.
- End of transfer:
  - DESEL is entered in the cycle after the last nibble is sampled; cs_n=1 and sck=0 from that cycle.
  - cs_n stays high ≥CS_HIGH_CLKS before req_ready rises again.
  - The final byte may still be pending on the stream.
- A new request cannot be accepted until the last byte has been accepted and the guard has elapsed.
- Byte counter is LEN_W bits and counts down from req_len. req_len=2^LEN_W−1 is legal; the counter does not wrap early.
- req_valid held while busy is ignored; req_addr/req_len are don't-care outside the handshake.

Decomposition:
- Package qspi_pkg holds:
  - state enum (IDLE, CMD, ADDR, DUMMY, DATA, DESEL);
  - pin-index constants PIN_CS=0, PIN_SCK=3, IO map {5,4,2,1};
  - OE_CMD=4'b1101.
- One sub-module, qspi_shift_reg: 32-bit shift register.
  - Loads {CMD, addr}, shifts 1 bit per slot out on the MSB.
  - Shifts in 4 bits per slot for data.
- The FSM, slot/phase counters and output register stay in qspi_read_ctrl.

Test Plan:
- Single-byte read:
  - Stimulus: addr=24'h000100, len=0; flash model returns 0x5A.
  - Response: cs_n low at C; io0 carries 0x6B then 0x000100 on sck rising edges; data_valid with 0x5A, data_last=1 at C+84; cs_n high at C+84.
- 16-byte burst:
  - Stimulus: addr=24'h012340, len=15, data_ready=1, model returns addr[7:0].
  - Response: bytes 0x40..0x4F, one every 4 clk; data_last only on 0x4F.
- Backpressure:
  - Stimulus: len=3, data_ready=0 for 20 clk after the first valid.
  - Response: sck frozen low with cs_n low; no byte lost or duplicated; bytes resume in order.
- Reset mid-ADDR:
  - Stimulus: assert rst at C+30.
  - Response: same cycle cs_n=1, sck=0, oe=0; after release, req_ready=1; a new read returns correct data.
- Back-to-back requests:
  - Stimulus: req_valid held high across two transfers.
  - Response: second cs_n fall ≥CS_HIGH_CLKS after the first rises; the second request is accepted only after the first's last byte is accepted.
- Max length:
  - Stimulus: len=255.
  - Response: exactly 256 bytes, data_last on the 256th.
